// File: rtl/bus_trace_checker.sv
// bus_trace_checker
//   Cycle-by-cycle checker for the processor bus. A programmable table of
//   expected per-cycle values (CPU state, BUS_ADDR, BUS_WE, ROM_ADDRESS) is
//   compared against the live bus after a START pulse. It reports a sticky
//   mismatch flag, the first failing entry with its failing fields, and a
//   saturating error count.
//
//   Optional feature macro: BUS_TRACE_STOP_ON_FAIL_EN
//     defined   - the first mismatch ends the run at the same edge
//     undefined - the run always covers all LEN entries
//
// Ports
//   CLK, RESET          clock (rising edge), asynchronous active-low reset
//   CPU_STATE, BUS_ADDR, BUS_WE, ROM_ADDRESS
//                       live signals, compared as they stand at each edge
//   LOAD_EN, LOAD_IDX, LOAD_MASK, LOAD_STATE, LOAD_BUS_ADDR, LOAD_WE,
//   LOAD_ROM_ADDR       table write port (ignored while a run is active)
//   LEN, START, CLEAR   run control; LEN is sampled on START
//   BUSY, DONE          run status
//   FLAG, FAIL_IDX, FAIL_FIELDS, ERR_COUNT
//                       run results (mask bit order: state, addr, we, rom)
module bus_trace_checker #(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned IDX_W   = 4,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned STATE_W = 8,
  parameter int unsigned ERR_W   = 8
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [STATE_W-1:0] CPU_STATE,
  input  logic [ADDR_W-1:0]  BUS_ADDR,
  input  logic               BUS_WE,
  input  logic [ADDR_W-1:0]  ROM_ADDRESS,
  input  logic               LOAD_EN,
  input  logic [IDX_W-1:0]   LOAD_IDX,
  input  logic [3:0]         LOAD_MASK,
  input  logic [STATE_W-1:0] LOAD_STATE,
  input  logic [ADDR_W-1:0]  LOAD_BUS_ADDR,
  input  logic               LOAD_WE,
  input  logic [ADDR_W-1:0]  LOAD_ROM_ADDR,
  input  logic [IDX_W:0]     LEN,
  input  logic               START,
  input  logic               CLEAR,
  output logic               BUSY,
  output logic               DONE,
  output logic               FLAG,
  output logic [IDX_W-1:0]   FAIL_IDX,
  output logic [3:0]         FAIL_FIELDS,
  output logic [ERR_W-1:0]   ERR_COUNT
);

  localparam logic [IDX_W:0] DEPTH_L = (IDX_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t r_state;

  logic [3:0]         r_mask      [DEPTH];
  logic [STATE_W-1:0] r_exp_state [DEPTH];
  logic [ADDR_W-1:0]  r_exp_addr  [DEPTH];
  logic               r_exp_we    [DEPTH];
  logic [ADDR_W-1:0]  r_exp_rom   [DEPTH];

  logic [IDX_W-1:0]   r_idx;
  logic [IDX_W:0]     r_len;

  logic               w_load;
  logic [IDX_W:0]     w_len_eff;
  logic [3:0]         w_fields;
  logic               w_mis;
  logic               w_last;
  logic               w_stop;

  // Table is frozen during a run so a compare never sees a half-written entry.
  assign w_load = LOAD_EN && (r_state != S_RUN) && ({1'b0, LOAD_IDX} < DEPTH_L);

  // Out-of-range lengths are clamped so the index never leaves the table.
  assign w_len_eff = (LEN > DEPTH_L) ? DEPTH_L : LEN;

  // Only the masks are reset; an all-zero mask makes the value fields inert.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mask[i] <= '0;
      end
    end else if (w_load) begin
      r_mask[LOAD_IDX] <= LOAD_MASK;
    end
  end

  always_ff @(posedge CLK) begin
    if (w_load) begin
      r_exp_state[LOAD_IDX] <= LOAD_STATE;
      r_exp_addr[LOAD_IDX]  <= LOAD_BUS_ADDR;
      r_exp_we[LOAD_IDX]    <= LOAD_WE;
      r_exp_rom[LOAD_IDX]   <= LOAD_ROM_ADDR;
    end
  end

  always_comb begin
    w_fields    = '0;
    w_fields[0] = r_mask[r_idx][0] && (CPU_STATE   != r_exp_state[r_idx]);
    w_fields[1] = r_mask[r_idx][1] && (BUS_ADDR    != r_exp_addr[r_idx]);
    w_fields[2] = r_mask[r_idx][2] && (BUS_WE      != r_exp_we[r_idx]);
    w_fields[3] = r_mask[r_idx][3] && (ROM_ADDRESS != r_exp_rom[r_idx]);
  end

  assign w_mis  = |w_fields;
  assign w_last = ({1'b0, r_idx} == (r_len - (IDX_W+1)'(1)));

`ifdef BUS_TRACE_STOP_ON_FAIL_EN
  assign w_stop = w_mis;
`else
  assign w_stop = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_len       <= '0;
      BUSY        <= 1'b0;
      DONE        <= 1'b0;
      FLAG        <= 1'b0;
      FAIL_IDX    <= '0;
      FAIL_FIELDS <= '0;
      ERR_COUNT   <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          // CLEAR and START both wipe results; CLEAR takes priority for the
          // next state.
          if (CLEAR || START) begin
            FLAG        <= 1'b0;
            FAIL_IDX    <= '0;
            FAIL_FIELDS <= '0;
            ERR_COUNT   <= '0;
          end
          if (CLEAR) begin
            r_state <= S_IDLE;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
          end else if (START) begin
            r_idx <= '0;
            r_len <= w_len_eff;
            if (w_len_eff == '0) begin
              r_state <= S_DONE;
              BUSY    <= 1'b0;
              DONE    <= 1'b1;
            end else begin
              r_state <= S_RUN;
              BUSY    <= 1'b1;
              DONE    <= 1'b0;
            end
          end
        end

        S_RUN: begin
          if (CLEAR) begin
            r_state     <= S_IDLE;
            BUSY        <= 1'b0;
            DONE        <= 1'b0;
            FLAG        <= 1'b0;
            FAIL_IDX    <= '0;
            FAIL_FIELDS <= '0;
            ERR_COUNT   <= '0;
          end else begin
            if (w_mis) begin
              FLAG <= 1'b1;
              if (ERR_COUNT != '1) begin
                ERR_COUNT <= ERR_COUNT + ERR_W'(1);
              end
              if (!FLAG) begin
                FAIL_IDX    <= r_idx;
                FAIL_FIELDS <= w_fields;
              end
            end
            r_idx <= r_idx + IDX_W'(1);
            if (w_last || w_stop) begin
              r_state <= S_DONE;
              BUSY    <= 1'b0;
              DONE    <= 1'b1;
            end
          end
        end

        default: begin
          r_state <= S_IDLE;
          BUSY    <= 1'b0;
          DONE    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_trace_checker.sv
module tb_bus_trace_checker;

  localparam int DEPTH = 16;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic [7:0] CPU_STATE = '0;
  logic [7:0] BUS_ADDR = '0;
  logic       BUS_WE = 1'b0;
  logic [7:0] ROM_ADDRESS = '0;
  logic       LOAD_EN = 1'b0;
  logic [3:0] LOAD_IDX = '0;
  logic [3:0] LOAD_MASK = '0;
  logic [7:0] LOAD_STATE = '0;
  logic [7:0] LOAD_BUS_ADDR = '0;
  logic       LOAD_WE = 1'b0;
  logic [7:0] LOAD_ROM_ADDR = '0;
  logic [4:0] LEN = '0;
  logic       START = 1'b0;
  logic       CLEAR = 1'b0;
  logic       BUSY, DONE, FLAG;
  logic [3:0] FAIL_IDX, FAIL_FIELDS;
  logic [7:0] ERR_COUNT;

  always #5 CLK = ~CLK;

  bus_trace_checker #(
    .DEPTH(16), .IDX_W(4), .ADDR_W(8), .STATE_W(8), .ERR_W(8)
  ) dut (
    .CLK(CLK), .RESET(RESET),
    .CPU_STATE(CPU_STATE), .BUS_ADDR(BUS_ADDR), .BUS_WE(BUS_WE), .ROM_ADDRESS(ROM_ADDRESS),
    .LOAD_EN(LOAD_EN), .LOAD_IDX(LOAD_IDX), .LOAD_MASK(LOAD_MASK), .LOAD_STATE(LOAD_STATE),
    .LOAD_BUS_ADDR(LOAD_BUS_ADDR), .LOAD_WE(LOAD_WE), .LOAD_ROM_ADDR(LOAD_ROM_ADDR),
    .LEN(LEN), .START(START), .CLEAR(CLEAR),
    .BUSY(BUSY), .DONE(DONE), .FLAG(FLAG), .FAIL_IDX(FAIL_IDX),
    .FAIL_FIELDS(FAIL_FIELDS), .ERR_COUNT(ERR_COUNT)
  );

  int checks = 0;
  int errors = 0;

  // Reference copy of the table and the live-input trace, one slot per entry.
  logic [3:0] m_mask  [DEPTH];
  logic [7:0] m_state [DEPTH];
  logic [7:0] m_ba    [DEPTH];
  logic       m_we    [DEPTH];
  logic [7:0] m_ra    [DEPTH];
  logic [7:0] tr_state[DEPTH];
  logic [7:0] tr_ba   [DEPTH];
  logic       tr_we   [DEPTH];
  logic [7:0] tr_ra   [DEPTH];

  logic [7:0] base_st[7] = '{8'h00, 8'h00, 8'h10, 8'h12, 8'h13, 8'h14, 8'h00};
  logic [7:0] base_ba[7] = '{8'hFF, 8'hFF, 8'hFF, 8'h10, 8'hFF, 8'hFF, 8'hFF};
  logic [7:0] base_ra[7] = '{8'h01, 8'h01, 8'h00, 8'h00, 8'h02, 8'h02, 8'h03};

  // fault: one nibble per entry, bit order state/addr/we/rom.
  typedef struct {
    logic [27:0] fault;
    int          e_flag;
    int          e_idx;
    int          e_fields;
    int          e_err;
    int          e_cyc;
    string       name;
  } vec_t;
  vec_t vt[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic load(input int idx, input logic [3:0] mask, input logic [7:0] st,
                      input logic [7:0] ba, input logic we, input logic [7:0] ra);
    LOAD_EN = 1'b1; LOAD_IDX = 4'(idx); LOAD_MASK = mask;
    LOAD_STATE = st; LOAD_BUS_ADDR = ba; LOAD_WE = we; LOAD_ROM_ADDR = ra;
    tick();
    LOAD_EN = 1'b0;
    m_mask[idx] = mask; m_state[idx] = st; m_ba[idx] = ba; m_we[idx] = we; m_ra[idx] = ra;
  endtask

  task automatic set_trace(input logic [27:0] fault);
    for (int k = 0; k < DEPTH; k++) begin
      if (k < 7) begin
        tr_state[k] = base_st[k] ^ (fault[4*k]   ? 8'hA5 : 8'h00);
        tr_ba[k]    = base_ba[k] ^ (fault[4*k+1] ? 8'hEF : 8'h00);
        tr_we[k]    = fault[4*k+2];
        tr_ra[k]    = base_ra[k] ^ (fault[4*k+3] ? 8'h3C : 8'h00);
      end else begin
        tr_state[k] = '0; tr_ba[k] = '0; tr_we[k] = 1'b0; tr_ra[k] = '0;
      end
    end
  endtask

  task automatic drive(input int k);
    if (k < DEPTH) begin
      CPU_STATE = tr_state[k]; BUS_ADDR = tr_ba[k]; BUS_WE = tr_we[k]; ROM_ADDRESS = tr_ra[k];
    end else begin
      CPU_STATE = '0; BUS_ADDR = '0; BUS_WE = 1'b0; ROM_ADDRESS = '0;
    end
  endtask

  // Returns the number of edges from the START edge to DONE (bounded).
  task automatic run(input int len, output int cyc);
    LEN = 5'(len); START = 1'b1;
    tick();
    START = 1'b0;
    if (len > 0) chk("run.busy_at_start", BUSY, 1);
    cyc = 0;
    while (!DONE && cyc < 40) begin
      drive(cyc);
      tick();
      cyc++;
    end
  endtask

  // Expected outcome of a run, straight from the checking rules.
  task automatic model(input int len, output int e_flag, output int e_idx,
                       output int e_fields, output int e_err, output int e_cyc);
    logic [3:0] f;
    e_flag = 0; e_idx = 0; e_fields = 0; e_err = 0; e_cyc = len;
    for (int k = 0; k < len; k++) begin
      f = '0;
      if (m_mask[k][0] && tr_state[k] != m_state[k]) f[0] = 1'b1;
      if (m_mask[k][1] && tr_ba[k]    != m_ba[k])    f[1] = 1'b1;
      if (m_mask[k][2] && tr_we[k]    != m_we[k])    f[2] = 1'b1;
      if (m_mask[k][3] && tr_ra[k]    != m_ra[k])    f[3] = 1'b1;
      if (f != 0) begin
        if (e_flag == 0) begin
          e_idx = k; e_fields = int'(f);
        end
        e_flag = 1;
        if (e_err < 255) e_err++;
`ifdef BUS_TRACE_STOP_ON_FAIL_EN
        e_cyc = k + 1;
        break;
`endif
      end
    end
  endtask

  task automatic chk_all(input string tag, input int cyc, input int e_flag, input int e_idx,
                         input int e_fields, input int e_err, input int e_cyc);
    chk({tag, ".cycles"}, cyc, e_cyc);
    chk({tag, ".done"}, DONE, 1);
    chk({tag, ".busy"}, BUSY, 0);
    chk({tag, ".flag"}, FLAG, e_flag);
    chk({tag, ".fail_idx"}, FAIL_IDX, e_idx);
    chk({tag, ".fail_fields"}, FAIL_FIELDS, e_fields);
    chk({tag, ".err_count"}, ERR_COUNT, e_err);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".busy"}, BUSY, 0);
    chk({tag, ".done"}, DONE, 0);
    chk({tag, ".flag"}, FLAG, 0);
    chk({tag, ".fail_idx"}, FAIL_IDX, 0);
    chk({tag, ".fail_fields"}, FAIL_FIELDS, 0);
    chk({tag, ".err_count"}, ERR_COUNT, 0);
  endtask

  // poke 1: table write mid-run, poke 2: START mid-run.
  task automatic run_poke(input int poke, output int cyc);
    LEN = 5'd7; START = 1'b1;
    tick();
    START = 1'b0;
    drive(0);
    if (poke == 1) begin
      LOAD_EN = 1'b1; LOAD_IDX = 4'd5; LOAD_MASK = 4'hF; LOAD_STATE = 8'h77;
      LOAD_BUS_ADDR = 8'h77; LOAD_WE = 1'b1; LOAD_ROM_ADDR = 8'h77;
    end else begin
      START = 1'b1; LEN = 5'd2;
    end
    tick();
    LOAD_EN = 1'b0; START = 1'b0; LEN = 5'd7;
    chk("poke.busy", BUSY, 1);
    cyc = 1;
    while (!DONE && cyc < 40) begin
      drive(cyc);
      tick();
      cyc++;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc, ef, ei, eff, ee, ec, len;

    vt[0] = '{28'h0000000, 0, 0, 0, 0, 7, "match"};
`ifdef BUS_TRACE_STOP_ON_FAIL_EN
    vt[1] = '{28'h0002000, 1, 3, 2, 1, 4, "addr_fault"};
    vt[2] = '{28'h0100100, 1, 2, 1, 1, 3, "two_state_faults"};
    vt[3] = '{28'h2000008, 1, 0, 8, 1, 1, "first_and_last"};
    vt[4] = '{28'h0090040, 1, 4, 9, 1, 5, "two_fields_we_masked"};
`else
    vt[1] = '{28'h0002000, 1, 3, 2, 1, 7, "addr_fault"};
    vt[2] = '{28'h0100100, 1, 2, 1, 2, 7, "two_state_faults"};
    vt[3] = '{28'h2000008, 1, 0, 8, 2, 7, "first_and_last"};
    vt[4] = '{28'h0090040, 1, 4, 9, 1, 7, "two_fields_we_masked"};
`endif

    for (int k = 0; k < DEPTH; k++) m_mask[k] = '0;

    // Reset state
    tick();
    chk_zero("reset");
    RESET = 1'b1;
    tick();

    for (int k = 0; k < 7; k++) load(k, 4'b1011, base_st[k], base_ba[k], 1'b0, base_ra[k]);

    // Table-driven trace vectors
    for (int v = 0; v < 5; v++) begin
      set_trace(vt[v].fault);
      run(7, cyc);
      chk_all(vt[v].name, cyc, vt[v].e_flag, vt[v].e_idx, vt[v].e_fields, vt[v].e_err, vt[v].e_cyc);
    end

    // LEN = 0 finishes at the START edge
    run(0, cyc);
    chk_all("len0", cyc, 0, 0, 0, 0, 0);

    // Table write and START during RUN are ignored
    set_trace(28'h0);
    run_poke(1, cyc);
    chk_all("load_in_run", cyc, 0, 0, 0, 0, 7);
    run_poke(2, cyc);
    chk_all("start_in_run", cyc, 0, 0, 0, 0, 7);

    // CLEAR with START wins and wipes results
    set_trace(28'h0002000);
    run(7, cyc);
    chk("clr_start.pre_flag", FLAG, 1);
    CLEAR = 1'b1; START = 1'b1; LEN = 5'd7;
    tick();
    CLEAR = 1'b0; START = 1'b0;
    chk_zero("clr_start");
    tick();
    chk("clr_start.stays_idle", BUSY, 0);

    // CLEAR during RUN aborts
    LEN = 5'd7; START = 1'b1;
    tick();
    START = 1'b0;
    for (int k = 0; k < 5; k++) begin drive(k); tick(); end
    chk("clr_run.pre_flag", FLAG, 1);
    CLEAR = 1'b1;
    tick();
    CLEAR = 1'b0;
    chk_zero("clr_run");

    // Randomized tables and traces against the model
    for (int k = 0; k < DEPTH; k++)
      load(k, 4'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 8'($urandom));
    for (int it = 0; it < 40; it++) begin
      for (int n = $urandom_range(0, 3); n > 0; n--)
        load($urandom_range(0, DEPTH-1), 4'($urandom), 8'($urandom), 8'($urandom),
             1'($urandom), 8'($urandom));
      for (int k = 0; k < DEPTH; k++) begin
        tr_state[k] = m_state[k] ^ (($urandom % 4 == 0) ? 8'($urandom_range(1, 255)) : 8'h00);
        tr_ba[k]    = m_ba[k]    ^ (($urandom % 4 == 0) ? 8'($urandom_range(1, 255)) : 8'h00);
        tr_we[k]    = m_we[k]    ^ ($urandom % 4 == 0);
        tr_ra[k]    = m_ra[k]    ^ (($urandom % 4 == 0) ? 8'($urandom_range(1, 255)) : 8'h00);
      end
      len = $urandom_range(0, DEPTH);
      model(len, ef, ei, eff, ee, ec);
      run(len, cyc);
      chk_all($sformatf("rand%0d", it), cyc, ef, ei, eff, ee, ec);
    end

    // Reset in the middle of a failing run
    for (int k = 0; k < 7; k++) load(k, 4'b1011, base_st[k], base_ba[k], 1'b0, base_ra[k]);
    set_trace(28'h0002000);
    LEN = 5'd7; START = 1'b1;
    tick();
    START = 1'b0;
    for (int k = 0; k < 4; k++) begin drive(k); tick(); end
    chk("rst_run.pre_flag", FLAG, 1);
    #2 RESET = 1'b0;
    #1;
    chk_zero("rst_run.async");
    tick();
    tick();
    RESET = 1'b1;
    for (int k = 0; k < DEPTH; k++) m_mask[k] = '0;
    tick();
    chk_zero("rst_run.after");
    set_trace(28'hFFFFFFF);
    model(7, ef, ei, eff, ee, ec);
    run(7, cyc);
    chk_all("rst_rerun", cyc, ef, ei, eff, ee, ec);
    chk("rst_rerun.flag_clear", FLAG, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
